// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch control sequencer.
//   sw_state_t  : FSM state encoding (INIT=0, IDLE=1, RUN=2, PAUSE=3, FULL=4)
//   SYNC_STAGES : depth of the button input synchronizer
//   cnt_width() : counter width able to hold 0..n-1 (never less than 1 bit)
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_FULL  = 3'd4
    } sw_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce
// Synchronizes one raw asynchronous button and debounces it.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   btn_raw  : raw button input (asynchronous)
//   level    : debounced button level
//   press    : one-cycle pulse on the debounced rising edge
// The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from it; releases produce no pulse.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], btn_raw};
            level_d <= level;
            press   <= level & ~level_d;
            // Any sample that agrees with the current level restarts the run.
            if (sync[SYNC_STAGES-1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[SYNC_STAGES-1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control sequencer for the stopwatch up-counter: debounces the buttons,
// runs the centisecond tick prescaler and tracks the run state.
// Optional feature macro: LAP_HOLD_EN (lap button toggles a display freeze).
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   btn_start  : raw start/stop button
//   btn_clear  : raw clear button
//   btn_lap    : raw lap button (only used with LAP_HOLD_EN)
//   cnt_full   : counter reads 99.99 (sampled directly)
//   ctr_reset  : one-cycle pulse to counter reset
//   ctr_toggle : one-cycle pulse to counter stopStart
//   tick       : one-cycle pulse every DIV cycles while running
//   running    : high in RUN
//   lap_hold   : display-freeze level
//   state      : current FSM state encoding
//
// state | meaning
// INIT  | after reset; pulses ctr_reset once, then IDLE
// IDLE  | counter cleared, waiting for start
// RUN   | counting; prescaler active, ticks issued
// PAUSE | counting stopped, value held
// FULL  | counter saturated at 99.99; only clear leaves
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       cnt_full,
    output logic       ctr_reset,
    output logic       ctr_toggle,
    output logic       tick,
    output logic       running,
    output logic       lap_hold,
    output logic [2:0] state
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic start_level, start_press;
    logic clear_level, clear_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_start),
        .level   (start_level),
        .press   (start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_clear),
        .level   (clear_level),
        .press   (clear_press)
    );

`ifdef LAP_HOLD_EN
    logic lap_level, lap_press;
    logic lap_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_lap),
        .level   (lap_level),
        .press   (lap_press)
    );

    logic unused_levels;
    assign unused_levels = ^{start_level, clear_level, lap_level};
`else
    logic unused_levels;
    assign unused_levels = ^{start_level, clear_level, btn_lap};
    assign lap_hold      = 1'b0;
`endif

    sw_state_t     state_q, state_d;
    logic [PW-1:0] presc, presc_d;
    logic          reset_d, toggle_d, tick_d, running_d;

    always_comb begin
        state_d  = state_q;
        reset_d  = 1'b0;
        toggle_d = 1'b0;
        tick_d   = 1'b0;
        presc_d  = '0;

        // Clear outranks cnt_full, which outranks start.
        case (state_q)
            ST_INIT: begin
                // First cycle out of reset raises ctr_reset; the next leaves.
                if (!ctr_reset) begin
                    reset_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_press) begin
                    reset_d = 1'b1;
                end else if (start_press) begin
                    toggle_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_press) begin
                    reset_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_full) begin
                    toggle_d = 1'b1;
                    state_d  = ST_FULL;
                end else if (start_press) begin
                    toggle_d = 1'b1;
                    state_d  = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clear_press) begin
                    reset_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (start_press) begin
                    toggle_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_FULL: begin
                if (clear_press) begin
                    reset_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Prescaler only advances while staying in RUN, so no tick can
        // coincide with leaving RUN and a resume restarts a full period.
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (presc == DIV_LAST) begin
                tick_d  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc + PW'(1);
            end
        end

        running_d = (state_d == ST_RUN);

`ifdef LAP_HOLD_EN
        lap_d = lap_hold;
        if (state_d == ST_IDLE) begin
            lap_d = 1'b0;
        end else if (state_q == ST_RUN && lap_press) begin
            lap_d = ~lap_hold;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            presc      <= '0;
            ctr_reset  <= 1'b0;
            ctr_toggle <= 1'b0;
            tick       <= 1'b0;
            running    <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc      <= presc_d;
            ctr_reset  <= reset_d;
            ctr_toggle <= toggle_d;
            tick       <= tick_d;
            running    <= running_d;
        end
    end

`ifdef LAP_HOLD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_hold <= 1'b0;
        end else begin
            lap_hold <= lap_d;
        end
    end
`endif

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Scoreboard bench for stopwatch_ctrl (DIV=10, DEBOUNCE_CYCLES=4).
// Each stimulus step predicts, from the button/state rules, the cycle-stamped
// events (ctr_reset, ctr_toggle, tick) it will cause and queues them; a
// monitor pops and compares whenever the DUT raises one of those outputs.
module tb_stopwatch_ctrl;

    localparam int DEB  = 4;
    localparam int DIVB = 10;
    localparam int LAT  = DEB + 4;

    localparam int S_INIT = 0, S_IDLE = 1, S_RUN = 2, S_PAUSE = 3, S_FULL = 4;
    localparam int K_RESET = 0, K_TOGGLE = 1, K_TICK = 2;
    localparam int A_START = 0, A_CLEAR = 1, A_BOTH = 2, A_GLITCH = 3, A_FULL = 4, A_LAP = 5;

`ifdef LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic       cnt_full = 1'b0;
    logic       ctr_reset, ctr_toggle, tick, running, lap_hold;
    logic [2:0] state;

    stopwatch_ctrl #(
        .CLK_HZ          (1000),
        .TICK_HZ         (100),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .btn_lap    (btn_lap),
        .cnt_full   (cnt_full),
        .ctr_reset  (ctr_reset),
        .ctr_toggle (ctr_toggle),
        .tick       (tick),
        .running    (running),
        .lap_hold   (lap_hold),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; outputs after edge N carry stamp N.
    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int cyc;
        int kind;
        int st;
        int lap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: abstract mode, lap flag and tick schedule.
    int m     = S_INIT;
    int m_lap = 0;
    bit run_on = 1'b0;
    int next_tick = 0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(input int c, input int k, input int s, input int l);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.st   = s;
        e.lap  = l;
        sb.push_back(e);
    endfunction

    function automatic void push_ticks(input int limit);
        while (run_on && next_tick <= limit) begin
            push(next_tick, K_TICK, S_RUN, m_lap);
            next_tick += DIVB;
        end
    endfunction

    task automatic observe(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, required none", k, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_state", int'(state), e.st);
            check("event_running", int'(running), (e.st == S_RUN) ? 1 : 0);
            check("event_lap_hold", int'(lap_hold), e.lap);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && cyc > 0) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event: kind %0d required at cycle %0d, no event by cycle %0d",
                         sb[0].kind, sb[0].cyc, cyc);
                sb.delete(0);
            end
            if (ctr_reset)  observe(K_RESET);
            if (ctr_toggle) observe(K_TOGGLE);
            if (tick)       observe(K_TICK);
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called with reset_n low; releases it and checks the INIT sequence.
    task automatic release_reset();
        repeat (2) @(negedge clk);
        m      = S_IDLE;
        m_lap  = 0;
        run_on = 1'b0;
        push(1, K_RESET, S_INIT, 0);
        reset_n = 1'b1;
        wait_until(2);
        check("post_reset_state", int'(state), S_IDLE);
        check("post_reset_ctr_reset", int'(ctr_reset), 0);
        check("post_reset_ctr_toggle", int'(ctr_toggle), 0);
        check("post_reset_tick", int'(tick), 0);
    endtask

    // Called on a falling edge; returns on the falling edge ending the step.
    task automatic apply(input int act);
        int n, x, kind, ns, nl, hold, gap, t_end;
        bit clr, st, lp, fl;
        n    = cyc;
        gap  = int'($urandom_range(0, 30));
        hold = LAT + int'($urandom_range(0, 3));
        clr  = (act == A_CLEAR) || (act == A_BOTH);
        st   = (act == A_START) || (act == A_BOTH);
        lp   = (act == A_LAP);
        fl   = (act == A_FULL);
        x    = fl ? n + 1 : n + LAT;
        kind = -1;
        ns   = m;
        nl   = m_lap;

        if (clr) begin
            kind = K_RESET;
            ns   = S_IDLE;
            nl   = 0;
        end else if (fl && m == S_RUN) begin
            kind = K_TOGGLE;
            ns   = S_FULL;
        end else if (st && (m == S_IDLE || m == S_PAUSE)) begin
            kind = K_TOGGLE;
            ns   = S_RUN;
        end else if (st && m == S_RUN) begin
            kind = K_TOGGLE;
            ns   = S_PAUSE;
        end else if (lp && m == S_RUN && LAP_EN) begin
            nl = 1 - m_lap;
        end

        push_ticks(x - 1);
        if (kind >= 0) push(x, kind, ns, nl);
        if (ns == S_RUN && m != S_RUN) begin
            run_on    = 1'b1;
            next_tick = x + DIVB;
        end
        if (ns != S_RUN) run_on = 1'b0;
        m     = ns;
        m_lap = nl;

        if (fl) t_end = n + 2 + gap;
        else if (act == A_GLITCH) t_end = n + 3 + DEB + 4 + gap;
        else t_end = n + hold + DEB + 4 + gap;
        push_ticks(t_end);

        if (fl) begin
            cnt_full = 1'b1;
            wait_until(n + 1);
            cnt_full = 1'b0;
        end else if (act == A_GLITCH) begin
            btn_start = 1'b1;
            wait_until(n + 3);
            btn_start = 1'b0;
        end else begin
            btn_start = st;
            btn_clear = clr;
            btn_lap   = lp;
            wait_until(n + hold);
            btn_start = 1'b0;
            btn_clear = 1'b0;
            btn_lap   = 1'b0;
        end
        wait_until(t_end);

        check("step_state", int'(state), m);
        check("step_running", int'(running), (m == S_RUN) ? 1 : 0);
        check("step_lap_hold", int'(lap_hold), m_lap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctr_reset"}, int'(ctr_reset), 0);
        check({tag, "_ctr_toggle"}, int'(ctr_toggle), 0);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_running"}, int'(running), 0);
        check({tag, "_lap_hold"}, int'(lap_hold), 0);
        check({tag, "_state"}, int'(state), S_INIT);
    endtask

    int directed[$] = '{A_START, A_GLITCH, A_START, A_START, A_FULL, A_START, A_CLEAR,
                        A_START, A_START, A_BOTH, A_START, A_LAP, A_LAP, A_GLITCH};

    initial begin
        #1;
        check_all_zero("in_reset");
        release_reset();

        foreach (directed[i]) apply(directed[i]);
        for (int i = 0; i < 50; i++) apply(int'($urandom_range(0, 5)));

        // Run with lap held, then abort mid-run with an asynchronous reset.
        apply(A_CLEAR);
        apply(A_START);
        apply(A_LAP);
        #2;
        check("queue_drained_before_reset", sb.size(), 0);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_run_reset");
        release_reset();
        apply(A_START);
        apply(A_START);
        #1;
        check("queue_drained_at_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch up-counter. It debounces the raw start/stop and clear buttons, runs the centisecond tick prescaler, and tracks the run state. It drives the counter's `reset`, `stopStart` and `tick` inputs with clean single-cycle pulses. It sits between the board buttons and the counter; the counter's own `mode`/`sw` preload behaviour is unchanged.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 100, tick rate; `DIV = CLK_HZ/TICK_HZ`, which must be an integer ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable samples required to accept a button level (≥ 1).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  raw start/stop button, asynchronous.
- `btn_clear`  in  1  raw clear button, asynchronous.
- `btn_lap`  in  1  raw lap button, asynchronous; used only with `LAP_HOLD_EN`.
- `cnt_full`  in  1  high while the counter reads 99.99.
- `ctr_reset`  out  1  one-cycle active-high pulse to the counter `reset`.
- `ctr_toggle`  out  1  one-cycle pulse to the counter `stopStart`.
- `tick`  out  1  one-cycle pulse every `DIV` cycles while running.
- `running`  out  1  high in RUN.
- `lap_hold`  out  1  display-freeze level.
- `state`  out  3  current FSM state encoding.

## Operation
- **Buttons**: each button passes through a 2-FF synchronizer, then a debounce counter. The debounced level flips only after `DEBOUNCE_CYCLES` consecutive synchronized samples that differ from it. A press is a one-cycle pulse on the debounced rising edge. Releases produce nothing.
- **FSM states**: INIT, IDLE, RUN, PAUSE, FULL.
- INIT: entered on reset. It asserts `ctr_reset` for exactly one cycle, then moves to IDLE.
- IDLE: on start press, pulse `ctr_toggle` and go to RUN. On clear press, pulse `ctr_reset` and stay in IDLE.
- RUN:
  - On start press, pulse `ctr_toggle` and go to PAUSE.
  - When `cnt_full` is high, pulse `ctr_toggle` and go to FULL.
  - On clear press, pulse `ctr_reset` and go to IDLE.
- PAUSE: on start press, pulse `ctr_toggle` and go to RUN. On clear press, pulse `ctr_reset` and go to IDLE.
- FULL: start presses are ignored. On clear press, pulse `ctr_reset` and go to IDLE.
- **Priority**: clear beats `cnt_full`, which beats start, when they arrive in the same cycle. `ctr_reset` and `ctr_toggle` are never high in the same cycle.
- **Prescaler**: a `$clog2(DIV)`-bit counter runs only in RUN and is held at 0 in all other states. `tick` is high when the prescaler equals `DIV-1`, and the prescaler then wraps to 0.
  - On resume from PAUSE, the next tick comes `DIV` cycles after entering RUN.
- `tick` is never high outside RUN, including the cycle in which RUN is exited.

## Timing
- **During reset** (`reset_n` low): state is INIT and every output is 0. Synchronizers, debounced levels, prescaler and `lap_hold` are all cleared.
- **First cycle after `reset_n` rises**: `ctr_reset`=1 and `state`=INIT.
- **Button latency**: a raw edge produces the press pulse `DEBOUNCE_CYCLES+3` cycles later. The FSM outputs (`ctr_toggle`/`ctr_reset`) and the state change follow one cycle after the pulse. Total: `DEBOUNCE_CYCLES+4` cycles.
- **`cnt_full` latency**: sampled directly, with no synchronization. `ctr_toggle` follows one cycle after it is seen high in RUN.
- **Reset mid-operation**: asserting `reset_n` at any point aborts immediately, including mid-debounce and mid-tick.
- **Timing of outputs**: all outputs are registered.

## Configuration
- **`LAP_HOLD_EN` defined**:
  - `btn_lap` is debounced the same way as the other buttons.
  - A lap press in RUN toggles `lap_hold`. Lap presses in other states are ignored.
  - `lap_hold` clears on any transition to IDLE or INIT. It is held through PAUSE and FULL.
- **`LAP_HOLD_EN` undefined**: `lap_hold` is tied to 0, `btn_lap` is unused, and no third debouncer is instantiated.

## Structure
- **`stopwatch_pkg`**: holds the state enum (INIT=0, IDLE=1, RUN=2, PAUSE=3, FULL=4) and the `SYNC_STAGES=2` constant.
- **Sub-module `btn_debounce`** (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset_n`, `btn_raw`, `level`, `press`): instantiated two times, or three with `LAP_HOLD_EN`.

## Test plan
Bench parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (so `DIV`=10), `DEBOUNCE_CYCLES`=4.

- **Reset release**: release `reset_n` → `ctr_reset` high for exactly cycle 1, then `state`=IDLE, and `tick`/`ctr_toggle` stay 0.
- **Start**: raise `btn_start` → `ctr_toggle` pulse 8 cycles later and `state`=RUN. Ticks then arrive every 10 cycles, the first 10 cycles after RUN entry.
- **Bounce**: glitch `btn_start` high for 3 cycles → no pulse. A second start press → PAUSE, with the tick stopping immediately and the prescaler returning to 0.
- **Full**: assert `cnt_full` in RUN → `ctr_toggle` the next cycle and `state`=FULL. A start press is then ignored, and a clear press → `ctr_reset` and IDLE.
- **Simultaneous presses**: start and clear presses land in the same cycle in PAUSE → only `ctr_reset` is pulsed, `state`=IDLE, and `ctr_toggle` stays 0.
- **Lap / mid-run reset**: with `LAP_HOLD_EN`, a lap press in RUN → `lap_hold`=1 while ticks continue. Asserting `reset_n` mid-run → all outputs 0 the same cycle, and `lap_hold` is cleared.
